fb_rect_filler: RTL and testbench

FB_RECT_FILLER -- requirements
Module: fb_rect_filler

---
 rtl/fb_rect_filler.sv | 144 ++++++++++++++
 tb/tb_fb_rect_filler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fb_rect_filler.sv
// Solid-colour rectangle filler: clips a command to the framebuffer and streams
// one pixel write per cycle in raster order with incrementally updated addresses.
module fb_rect_filler #(
   parameter  int FB_X         = 1280,
   parameter  int FB_Y         = 720,
   localparam int X_BITS       = $clog2(FB_X),
   localparam int Y_BITS       = $clog2(FB_Y),
   localparam int FB_ADDR_BITS = $clog2(FB_X*FB_Y)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [X_BITS-1:0]       cmd_x_i,
   input  logic [Y_BITS-1:0]       cmd_y_i,
   input  logic [X_BITS:0]         cmd_w_i,
   input  logic [Y_BITS:0]         cmd_h_i,
   input  logic [23:0]             cmd_color_i,
   output logic [FB_ADDR_BITS-1:0] pxl_addr_o,
   output logic [23:0]             pxl_data_o,
   output logic                    pxl_en_o,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam logic [X_BITS+1:0]       FBX_S = (X_BITS+2)'(FB_X);
   localparam logic [Y_BITS+1:0]       FBY_S = (Y_BITS+2)'(FB_Y);
   localparam logic [FB_ADDR_BITS-1:0] FBX_A = FB_ADDR_BITS'(FB_X);

   typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
   state_t r_state;

   logic [X_BITS-1:0]       r_x0;
   logic [Y_BITS-1:0]       r_y0;
   logic [X_BITS:0]         r_w, r_x, r_x_end;
   logic [Y_BITS:0]         r_h, r_y, r_y_end;
   logic [23:0]             r_data;
   logic [FB_ADDR_BITS-1:0] r_addr, r_row_base;
   logic                    r_ready, r_busy, r_done, r_pxl_en;

   // Setup-time clipping; the only multiply is here, never in the fill loop.
   logic [X_BITS+1:0]       w_x_sum;
   logic [Y_BITS+1:0]       w_y_sum;
   logic [X_BITS:0]         w_x_end, w_x_nxt;
   logic [Y_BITS:0]         w_y_end, w_y_nxt;
   logic [FB_ADDR_BITS-1:0] w_row0, w_wrap_base;
   logic                    w_empty, w_last_x, w_last_y;

   assign w_x_sum     = {2'b0, r_x0} + {1'b0, r_w};
   assign w_y_sum     = {2'b0, r_y0} + {1'b0, r_h};
   assign w_x_end     = (w_x_sum > FBX_S) ? FBX_S[X_BITS:0] : w_x_sum[X_BITS:0];
   assign w_y_end     = (w_y_sum > FBY_S) ? FBY_S[Y_BITS:0] : w_y_sum[Y_BITS:0];
   assign w_row0      = FB_ADDR_BITS'(r_y0) * FBX_A;
   assign w_empty     = (r_w == '0) || (r_h == '0) ||
                        ({2'b0, r_x0} >= FBX_S) || ({2'b0, r_y0} >= FBY_S);
   assign w_x_nxt     = r_x + 1'b1;
   assign w_y_nxt     = r_y + 1'b1;
   assign w_last_x    = (w_x_nxt == r_x_end);
   assign w_last_y    = (w_y_nxt == r_y_end);
   assign w_wrap_base = r_row_base + FBX_A;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_x0       <= '0;
         r_y0       <= '0;
         r_w        <= '0;
         r_h        <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_x_end    <= '0;
         r_y_end    <= '0;
         r_data     <= '0;
         r_addr     <= '0;
         r_row_base <= '0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pxl_en   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cmd_valid_i && r_ready) begin
                  r_x0    <= cmd_x_i;
                  r_y0    <= cmd_y_i;
                  r_w     <= cmd_w_i;
                  r_h     <= cmd_h_i;
                  r_data  <= cmd_color_i;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= SETUP;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            SETUP: begin
               r_x_end    <= w_x_end;
               r_y_end    <= w_y_end;
               r_x        <= {1'b0, r_x0};
               r_y        <= {1'b0, r_y0};
               r_row_base <= w_row0;
               r_addr     <= w_row0 + FB_ADDR_BITS'(r_x0);
               if (w_empty) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_pxl_en <= 1'b1;
                  r_state  <= FILL;
               end
            end
            FILL: begin
               if (w_last_x && w_last_y) begin
                  r_pxl_en <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end else if (w_last_x) begin
                  r_x        <= {1'b0, r_x0};
                  r_y        <= w_y_nxt;
                  r_row_base <= w_wrap_base;
                  r_addr     <= w_wrap_base + FB_ADDR_BITS'(r_x0);
               end else begin
                  r_x    <= w_x_nxt;
                  r_addr <= r_addr + 1'b1;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cmd_ready_o = r_ready;
   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign pxl_en_o    = r_pxl_en;
   assign pxl_addr_o  = r_addr;
   assign pxl_data_o  = r_data;

endmodule

// File: tb/tb_fb_rect_filler.sv
// Scoreboard bench for fb_rect_filler: each accepted command pushes its clipped
// raster of expected writes (with due cycle) and its done cycle; a monitor pops them.
module tb_fb_rect_filler;

   localparam int FX = 1280;
   localparam int FY = 720;
   localparam int XB = 11;
   localparam int YB = 10;
   localparam int AB = 20;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          cmd_valid_i = 1'b0;
   logic          cmd_ready_o;
   logic [XB-1:0] cmd_x_i = '0;
   logic [YB-1:0] cmd_y_i = '0;
   logic [XB:0]   cmd_w_i = '0;
   logic [YB:0]   cmd_h_i = '0;
   logic [23:0]   cmd_color_i = '0;
   logic [AB-1:0] pxl_addr_o;
   logic [23:0]   pxl_data_o;
   logic          pxl_en_o, busy_o, done_o;

   fb_rect_filler #(.FB_X(FX), .FB_Y(FY)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_x_i(cmd_x_i), .cmd_y_i(cmd_y_i), .cmd_w_i(cmd_w_i), .cmd_h_i(cmd_h_i),
      .cmd_color_i(cmd_color_i),
      .pxl_addr_o(pxl_addr_o), .pxl_data_o(pxl_data_o), .pxl_en_o(pxl_en_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {int cyc; logic [AB-1:0] addr; logic [23:0] data;} wr_t;
   wr_t wq[$];
   int  dq[$];
   int  cyc = 0;
   int  ready_due = -1;
   int  n_vec = 0;
   int  n_bad = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: every write and done pulse must match the head of its queue.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (pxl_en_o) begin
            if (wq.size() == 0) chk("unexp_wr", {44'd0, pxl_addr_o}, 64'hFFFF_FFFF);
            else begin
               wr_t e;
               e = wq.pop_front();
               chk("wr_cyc", 64'(cyc), 64'(e.cyc));
               chk("wr_addr", 64'(pxl_addr_o), 64'(e.addr));
               chk("wr_data", 64'(pxl_data_o), 64'(e.data));
            end
         end
         if (done_o) begin
            if (dq.size() == 0) chk("unexp_done", 64'(cyc), 64'hFFFF_FFFF);
            else chk("done_cyc", 64'(cyc), 64'(dq.pop_front()));
            ready_due = cyc + 1;
         end
         if (cyc == ready_due) chk("rdy_after_done", 64'(cmd_ready_o), 64'd1);
         if (busy_o) chk("rdy_busy", 64'(cmd_ready_o), 64'd0);
      end
   end

   // Drive a command, wait for its accept cycle and push the model's expectations.
   task automatic send(input int x, input int y, input int w, input int h,
                       input logic [23:0] col, output int acc, output int done_at);
      int xe, ye, k;
      cmd_x_i = XB'(x); cmd_y_i = YB'(y); cmd_w_i = (XB+1)'(w); cmd_h_i = (YB+1)'(h);
      cmd_color_i = col; cmd_valid_i = 1'b1;
      acc = -1; done_at = -1;
      for (int t = 0; t < 5000; t++) begin
         @(negedge clk_i);
         if (cmd_ready_o) begin acc = cyc; break; end
      end
      if (acc < 0) begin
         chk("accept_timeout", 64'd0, 64'd1);
      end else begin
         k = 0;
         if (w != 0 && h != 0 && x < FX && y < FY) begin
            xe = (x + w > FX) ? FX : x + w;
            ye = (y + h > FY) ? FY : y + h;
            for (int yy = y; yy < ye; yy++)
               for (int xx = x; xx < xe; xx++) begin
                  wr_t e;
                  e.cyc = acc + 2 + k; e.addr = AB'(yy * FX + xx); e.data = col;
                  wq.push_back(e);
                  k++;
               end
         end
         done_at = acc + 2 + k;
         dq.push_back(done_at);
      end
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int t;
      t = 0;
      while ((wq.size() != 0 || dq.size() != 0) && t < budget) begin
         @(posedge clk_i); t++;
      end
      if (t >= budget) chk("drain_timeout", 64'(wq.size() + dq.size()), 64'd0);
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   int a1, d1, a2, d2;

   initial begin
      #2 rst_i = 1'b1;
      #1;
      chk("rst_rdy", 64'(cmd_ready_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_en", 64'(pxl_en_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_addr", 64'(pxl_addr_o), 64'd0);
      chk("rst_data", 64'(pxl_data_o), 64'd0);
      repeat (2) @(posedge clk_i);
      #3 rst_i = 1'b0;
      #1 chk("rdy_pre_edge", 64'(cmd_ready_o), 64'd0);
      @(posedge clk_i); #1;
      chk("rdy_post_rst", 64'(cmd_ready_o), 64'd1);

      send(0, 0, 2, 2, 24'hFF0000, a1, d1);
      wait_idle(100);
      send(1279, 719, 4, 4, 24'h00FF00, a1, d1);
      wait_idle(100);
      send(10, 10, 0, 5, 24'hABCDEF, a1, d1);
      wait_idle(100);
      send(1300, 5, 3, 3, 24'h010203, a1, d1);
      wait_idle(100);
      send(5, 800, 3, 3, 24'h040506, a1, d1);
      wait_idle(100);
      send(1200, 700, 200, 40, 24'h7E7E7E, a1, d1);
      wait_idle(5000);

      // Back-to-back with valid held: second accept one cycle after first done.
      send(5, 5, 3, 2, 24'h111111, a1, d1);
      send(1270, 0, 20, 2, 24'h222222, a2, d2);
      chk("b2b_gap", 64'(a2), 64'(d1 + 1));
      wait_idle(200);

      for (int i = 0; i < 4; i++) begin
         send($urandom_range(1260, 1279), $urandom_range(700, 719), $urandom_range(0, 30),
              $urandom_range(0, 25), 24'($urandom), a1, d1);
         wait_idle(2000);
      end

      // Reset pulse in the middle of a fill abandons the command.
      send(100, 100, 50, 50, 24'h5A5A5A, a1, d1);
      repeat (10) @(posedge clk_i);
      #3 rst_i = 1'b1;
      #1;
      wq.delete(); dq.delete(); ready_due = -1;
      chk("mid_rst_en", 64'(pxl_en_o), 64'd0);
      chk("mid_rst_busy", 64'(busy_o), 64'd0);
      chk("mid_rst_done", 64'(done_o), 64'd0);
      chk("mid_rst_rdy", 64'(cmd_ready_o), 64'd0);
      @(posedge clk_i);
      #3 rst_i = 1'b0;
      @(posedge clk_i); #1;
      chk("mid_rst_rdy_up", 64'(cmd_ready_o), 64'd1);
      repeat (20) @(posedge clk_i);
      #1 chk("mid_rst_idle", 64'(busy_o), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
